ro_puf_controller: RTL and testbench



---
 rtl/ro_puf_pkg.sv | 9 +
 rtl/ro_edge_counter.sv | 34 +++
 rtl/ro_puf_controller.sv | 123 ++++++++++++
 tb/tb_ro_puf_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM states, pipeline depths and challenge check for the RO PUF controller.
package ro_puf_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, DRAIN, COMPARE, RESP} state_t;
    localparam int SYNC_DEPTH = 2;
    localparam int DRAIN_CYCLES = SYNC_DEPTH + 1;
    function automatic logic chal_ok(input int a, input int b, input int n);
        return a != b && a < n && b < n;
    endfunction
endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronizes one raw ring output, detects rising edges and counts them
// into a saturating counter gated by enable.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ring,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);
    logic [SYNC_DEPTH-1:0] sync;
    logic prev, rise;
    // rise is registered so a sample taken in cycle c reaches the counter in c+DRAIN_CYCLES
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            count <= '0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], ring};
            prev <= sync[SYNC_DEPTH-1];
            rise <= sync[SYNC_DEPTH-1] && !prev;
            if (clear)
                count <= '0;
            else if (enable && rise && count != '1)
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/ro_puf_controller.sv
// ro_puf_controller: enables a ring pair, counts edges over a window and returns one PUF bit.
// Define RO_PUF_MAJORITY_EN for three measurement rounds with a majority vote.
module ro_puf_controller
    import ro_puf_pkg::*;
#(
    parameter int N_RO          = 8,
    parameter int IDX_W         = $clog2(N_RO),
    parameter int CNT_W         = 16,
    parameter int WINDOW        = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] chal_a,
    input  logic [IDX_W-1:0] chal_b,
    output logic [N_RO-1:0]  ro_enable,
    input  logic [N_RO-1:0]  ro_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             response,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             tie,
    output logic             err
);
    state_t state, next;
    logic [31:0] timer;
    logic [IDX_W-1:0] sel_a, sel_b;
    logic [DRAIN_CYCLES-1:0] win_d;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic accept, clear, last, vote, ok;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign ok         = chal_ok(int'(chal_a), int'(chal_b), N_RO);
    assign clear      = accept || state == COMPARE;
    assign vote       = cnt_a > cnt_b;

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0] rnd, votes;
    assign last = rnd == 2'd2;
`else
    assign last = 1'b1;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = ok ? SETTLE : RESP;
            SETTLE:  if (timer == 32'(SETTLE_CYCLES - 1)) next = COUNT;
            COUNT:   if (timer == 32'(WINDOW - 1)) next = DRAIN;
            DRAIN:   if (timer == 32'(DRAIN_CYCLES - 1)) next = COMPARE;
            COMPARE: next = last ? RESP : SETTLE;
            RESP:    if (resp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        ro_enable = '0;
        if (state == SETTLE || state == COUNT) begin
            ro_enable[sel_a] = 1'b1;
            ro_enable[sel_b] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            win_d    <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
`ifdef RO_PUF_MAJORITY_EN
            rnd      <= '0;
            votes    <= '0;
`endif
        end else begin
            state <= next;
            timer <= next == state ? timer + 32'd1 : '0;
            win_d <= {win_d[DRAIN_CYCLES-2:0], state == COUNT};
            if (accept) begin
                sel_a    <= chal_a;
                sel_b    <= chal_b;
                err      <= !ok;
                response <= 1'b0;
                tie      <= 1'b0;
                count_a  <= '0;
                count_b  <= '0;
            end
            if (state == COMPARE) begin
                count_a <= cnt_a;
                count_b <= cnt_b;
                tie     <= cnt_a == cnt_b;
`ifdef RO_PUF_MAJORITY_EN
                rnd      <= last ? 2'd0 : rnd + 2'd1;
                votes    <= {votes[0], vote};
                response <= last && ((votes[1] && votes[0]) || (vote && (votes[1] || votes[0])));
`else
                response <= vote;
`endif
            end
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk(clk), .reset_n(reset_n), .ring(ro_out[sel_a]), .clear(clear),
        .enable(win_d[DRAIN_CYCLES-1]), .count(cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk(clk), .reset_n(reset_n), .ring(ro_out[sel_b]), .clear(clear),
        .enable(win_d[DRAIN_CYCLES-1]), .count(cnt_b)
    );
endmodule

// File: tb/tb_ro_puf_controller.sv
// tb_ro_puf_controller: two controllers (wide counters / 4-bit counters) driven by modelled rings;
// expected responses are queued on request and checked when the response appears.
module tb_ro_puf_controller;
    localparam int N  = 8;
    localparam int S  = 8;
    localparam int W0 = 96;
    localparam int W1 = 64;
`ifdef RO_PUF_MAJORITY_EN
    localparam int ROUNDS = 3;
`else
    localparam int ROUNDS = 1;
`endif

    typedef struct {
        logic rsp;
        logic tie;
        logic err;
        int   ca;
        int   cb;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] chal_a = '0, chal_b = '0;
    logic resp_ready = 1'b0;
    logic req_valid[2];
    logic req_ready[2], resp_valid[2], response[2], tie[2], err[2];
    logic [N-1:0] ro_enable[2], ro_out[2];
    logic [15:0] ca0, cb0;
    logic [3:0] ca1, cb1;
    int per[2][N], per2[2][N], ph[2][N], rn[2][N];
    int total = 0, bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ro_puf_controller #(.N_RO(N), .CNT_W(16), .WINDOW(W0), .SETTLE_CYCLES(S)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .chal_a(chal_a), .chal_b(chal_b), .ro_enable(ro_enable[0]), .ro_out(ro_out[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .response(response[0]),
        .count_a(ca0), .count_b(cb0), .tie(tie[0]), .err(err[0])
    );

    ro_puf_controller #(.N_RO(N), .CNT_W(4), .WINDOW(W1), .SETTLE_CYCLES(S)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .chal_a(chal_a), .chal_b(chal_b), .ro_enable(ro_enable[1]), .ro_out(ro_out[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .response(response[1]),
        .count_a(ca1), .count_b(cb1), .tie(tie[1]), .err(err[1])
    );

    // ring model: starts low when enabled, period in clk cycles, optional alternate period in round 2
    always @(negedge clk) begin
        int p;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                if (req_ready[d]) rn[d][i] = 0;
                if (!ro_enable[d][i]) begin
                    ph[d][i] = 0;
                    ro_out[d][i] = 1'b0;
                end else begin
                    if (ph[d][i] == 0) rn[d][i]++;
                    p = (rn[d][i] == 2 && per2[d][i] != 0) ? per2[d][i] : per[d][i];
                    ro_out[d][i] = (ph[d][i] % p) >= p / 2;
                    ph[d][i]++;
                end
            end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int obs_a(input int d);
        return d != 0 ? int'(ca1) : int'(ca0);
    endfunction

    function automatic int obs_b(input int d);
        return d != 0 ? int'(cb1) : int'(cb0);
    endfunction

    task automatic run(input int d, input int a, input int b, input int pa, input int pb,
                       input int alt, input logic rsp, input logic t, input logic e,
                       input int xa, input int xb, input int hold);
        exp_t x, y;
        int n = 0, w, o_ca, o_cb;
        logic [N-1:0] mask;
        logic seen_rdy = 1'b0, stable = 1'b1, o_rsp, o_tie;
        w = d != 0 ? W1 : W0;
        per[d][a] = pa;
        per[d][b] = pb;
        per2[d][b] = 0;
        per2[d][a] = alt;
        mask = e ? '0 : (N'(1) << a) | (N'(1) << b);
        x = '{rsp: rsp, tie: t, err: e, ca: xa, cb: xb, lat: e ? 1 : ROUNDS * (S + w + 4) + 1};
        sb.push_back(x);
        @(negedge clk);
        check("req_ready", req_ready[d], 1);
        chal_a = 3'(a);
        chal_b = 3'(b);
        req_valid[d] = 1'b1;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("ro_enable", ro_enable[d], mask);
        end while (!resp_valid[d] && n < 5000);
        y = sb.pop_front();
        if (!resp_valid[d]) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("latency", n, y.lat);
        check("response", response[d], y.rsp);
        check("tie", tie[d], y.tie);
        check("err", err[d], y.err);
        check("count_a", obs_a(d), y.ca);
        check("count_b", obs_b(d), y.cb);
        check("ro_enable_off", ro_enable[d], 0);
        if (hold > 0) begin
            o_rsp = response[d];
            o_tie = tie[d];
            o_ca = obs_a(d);
            o_cb = obs_b(d);
            chal_a = 3'd0;
            chal_b = 3'd1;
            req_valid[d] = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                seen_rdy |= req_ready[d];
                stable &= resp_valid[d] && response[d] == o_rsp && tie[d] == o_tie &&
                          obs_a(d) == o_ca && obs_b(d) == o_cb && ro_enable[d] == '0;
            end
            req_valid[d] = 1'b0;
            check("hold_stable", stable, 1);
            check("hold_req_ready", seen_rdy, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("ready_after_resp", req_ready[d], 1);
        check("valid_cleared", resp_valid[d], 0);
    endtask

    initial begin
        logic seen;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                per[d][i] = 4;
                per2[d][i] = 0;
            end
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready[0], 1);
        check("rst_resp_valid", resp_valid[0], 0);
        check("rst_ro_enable", {ro_enable[1], ro_enable[0]}, 0);
        check("rst_outputs", {response[0], tie[0], err[0], ca0, cb0}, 0);
        reset_n = 1'b1;

        run(0, 2, 5, 4, 6, 0, 1'b1, 1'b0, 1'b0, 24, 16, 0);
        run(1, 1, 6, 8, 8, 0, 1'b0, 1'b1, 1'b0, 8, 8, 0);
        run(0, 3, 3, 4, 4, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        run(1, 0, 7, 2, 8, 0, 1'b1, 1'b0, 1'b0, 15, 8, 0);
        run(0, 4, 1, 6, 4, 0, 1'b0, 1'b0, 1'b0, 16, 24, 20);
`ifdef RO_PUF_MAJORITY_EN
        run(0, 2, 5, 4, 6, 8, 1'b1, 1'b0, 1'b0, 24, 16, 0);
`endif

        // reset in the middle of the count window
        per[0][0] = 4;
        per[0][3] = 6;
        per2[0][0] = 0;
        per2[0][3] = 0;
        @(negedge clk);
        chal_a = 3'd0;
        chal_b = 3'd3;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (S + 20) @(negedge clk);
        check("mid_count_enable", ro_enable[0], 8'b0000_1001);
        #2 reset_n = 1'b0;
        #1 check("reset_disables", ro_enable[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", req_ready[0], 1);
        seen = 1'b0;
        repeat (W0 + 40) begin
            @(negedge clk);
            seen |= resp_valid[0];
        end
        check("no_resp_after_reset", seen, 0);

        run(0, 6, 0, 6, 4, 0, 1'b0, 1'b0, 1'b0, 16, 24, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
